// File: rtl/mul_div_sequencer.sv
// Iterative signed multiply/divide for the Z register pair: radix-4 Booth multiplier and
// 32-step restoring divider on a shared accumulator. Define MULDIV_DIV_EN to include the divider.
module mul_div_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] ZhighOut,
   output logic [31:0] ZlowOut
);
   localparam int         DATA_W   = 32;
   localparam logic [4:0] MUL_LAST = 5'd15;

`ifdef MULDIV_DIV_EN
   localparam logic [4:0] DIV_LAST = 5'd31;
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

   state_t state, state_nxt;

   // acc holds {hi, lo} of the product during MUL and {rem, quo} during DIV
   logic [2*DATA_W-1:0]        acc;
   logic [DATA_W-1:0]          opnd;
   logic                       carry;
   logic [4:0]                 cnt;
   logic                       accept;
   logic signed [DATA_W+1:0]   booth_sum;
   logic [2*DATA_W-1:0]        mul_next;

`ifdef MULDIV_DIV_EN
   logic                       sign_a;
   logic                       neg_q;
   logic                       dz;
   logic [DATA_W-1:0]          rem_sh;
   logic [DATA_W:0]            trial;
   logic [2*DATA_W-1:0]        div_next;
   logic [DATA_W-1:0]          quo_fix;
   logic [DATA_W-1:0]          rem_fix;
`endif

   function automatic logic signed [DATA_W+1:0] booth_addend(input logic [2:0] sel,
                                                            input logic [DATA_W-1:0] m);
      logic signed [DATA_W+1:0] m1;
      logic signed [DATA_W+1:0] m2;
      m1 = {{2{m[DATA_W-1]}}, m};
      m2 = {m[DATA_W-1], m, 1'b0};
      case (sel)
         3'b001, 3'b010: booth_addend = m1;
         3'b011:         booth_addend = m2;
         3'b100:         booth_addend = -m2;
         3'b101, 3'b110: booth_addend = -m1;
         default:        booth_addend = '0;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] negate_if(input logic neg, input logic [DATA_W-1:0] x);
      negate_if = neg ? (~x + 32'd1) : x;
   endfunction

   // -2^31 maps to 0x80000000, which is still correct as an unsigned magnitude
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
      magnitude = negate_if(x[DATA_W-1], x);
   endfunction

`ifdef MULDIV_DIV_EN
   assign accept = (state == S_IDLE) && start;
`else
   assign accept = (state == S_IDLE) && start && !op;
`endif

   always_comb begin
      booth_sum = $signed({acc[2*DATA_W-1], acc[2*DATA_W-1], acc[2*DATA_W-1:DATA_W]})
                  + booth_addend({acc[1:0], carry}, opnd);
      mul_next  = {booth_sum, acc[DATA_W-1:2]};
   end

`ifdef MULDIV_DIV_EN
   always_comb begin
      rem_sh   = {acc[2*DATA_W-2:DATA_W], acc[DATA_W-1]};
      trial    = {1'b0, rem_sh} - {1'b0, opnd};
      div_next = trial[DATA_W] ? {rem_sh, acc[DATA_W-2:0], 1'b0}
                               : {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      quo_fix  = negate_if(neg_q, acc[DATA_W-1:0]);
      rem_fix  = negate_if(sign_a, acc[2*DATA_W-1:DATA_W]);
   end
`endif

   always_ff @(posedge clock) begin
      if (!clear) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
`ifdef MULDIV_DIV_EN
               state_nxt = op ? S_DIV : S_MUL;
`else
               state_nxt = S_MUL;
`endif
            end
         end
         S_MUL:  if (cnt == MUL_LAST) state_nxt = S_DONE;
`ifdef MULDIV_DIV_EN
         S_DIV: begin
            if (dz)                    state_nxt = S_DONE;
            else if (cnt == DIV_LAST)  state_nxt = S_FIX;
         end
         S_FIX:  state_nxt = S_DONE;
`endif
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
`ifdef MULDIV_DIV_EN
      div_by_zero = (state == S_DONE) && dz;
`else
      div_by_zero = 1'b0;
`endif
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         acc      <= '0;
         opnd     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         ZhighOut <= '0;
         ZlowOut  <= '0;
`ifdef MULDIV_DIV_EN
         sign_a   <= 1'b0;
         neg_q    <= 1'b0;
         dz       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt   <= '0;
                  carry <= 1'b0;
`ifdef MULDIV_DIV_EN
                  dz    <= 1'b0;
                  if (op) begin
                     sign_a <= a_in[DATA_W-1];
                     neg_q  <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
                     opnd   <= magnitude(b_in);
                     if (b_in == '0) begin
                        dz  <= 1'b1;
                        acc <= {{DATA_W{1'b0}}, a_in};
                     end else begin
                        acc <= {{DATA_W{1'b0}}, magnitude(a_in)};
                     end
                  end else
`endif
                  begin
                     acc  <= {{DATA_W{1'b0}}, b_in};
                     opnd <= a_in;
                  end
               end
            end
            S_MUL: begin
               acc   <= mul_next;
               carry <= acc[1];
               cnt   <= cnt + 5'd1;
               if (cnt == MUL_LAST) begin
                  ZhighOut <= mul_next[2*DATA_W-1:DATA_W];
                  ZlowOut  <= mul_next[DATA_W-1:0];
               end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
               if (dz) begin
                  ZhighOut <= acc[DATA_W-1:0];
                  ZlowOut  <= '1;
               end else begin
                  acc <= div_next;
                  cnt <= cnt + 5'd1;
               end
            end
            S_FIX: begin
               ZhighOut <= rem_fix;
               ZlowOut  <= quo_fix;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: reset, MUL vectors, ignored starts, abort,
// and DIV (or the DIV-disabled behaviour when MULDIV_DIV_EN is not defined).
module tb_mul_div_sequencer;
   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic        op;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] ZhighOut;
   logic [31:0] ZlowOut;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   mul_div_sequencer dut (
      .clock(clock), .clear(clear), .start(start), .op(op),
      .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .ZhighOut(ZhighOut), .ZlowOut(ZlowOut)
   );

   // Issues one op and returns at the negedge where done is seen (cyc = -1 on timeout).
   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic [31:0] zh, output logic [31:0] zl,
                         output logic dz, output logic bs);
      @(negedge clock);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(posedge clock);
      #1;
      start = 1'b0; op = ~o; a_in = $urandom; b_in = $urandom;
      cyc = -1; zh = '0; zl = '0; dz = 1'b0; bs = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (done) begin
            cyc = i + 1; zh = ZhighOut; zl = ZlowOut; dz = div_by_zero; bs = busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      clear = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", div_by_zero); else passed++;
      total++; if (ZhighOut !== 32'h0) $display("FAIL reset_zhigh: got %h want 0", ZhighOut); else passed++;
      total++; if (ZlowOut !== 32'h0) $display("FAIL reset_zlow: got %h want 0", ZlowOut); else passed++;
      clear = 1'b1;
   endtask

   task automatic test_mul();
      logic [31:0] va [5] = '{32'd7, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFB, 32'h00012345};
      logic [31:0] vb [5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00010000};
      logic [31:0] eh [5] = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      logic [31:0] el [5] = '{32'hFFFFFFEB, 32'h00000000, 32'h80000001, 32'h0000001E, 32'h23450000};
      int cyc; logic [31:0] zh; logic [31:0] zl; logic dz; logic bs;
      for (int i = 0; i < 5; i++) begin
         run_op(1'b0, va[i], vb[i], cyc, zh, zl, dz, bs);
         total++; if (cyc != 17) $display("FAIL mul%0d_latency: got %0d want 17", i, cyc); else passed++;
         total++; if (zh !== eh[i]) $display("FAIL mul%0d_zhigh: got %h want %h", i, zh, eh[i]); else passed++;
         total++; if (zl !== el[i]) $display("FAIL mul%0d_zlow: got %h want %h", i, zl, el[i]); else passed++;
         total++; if (bs !== 1'b1 || dz !== 1'b0)
            $display("FAIL mul%0d_flags: got busy=%b dbz=%b want busy=1 dbz=0", i, bs, dz); else passed++;
         @(negedge clock);
         total++; if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL mul%0d_after: got done=%b busy=%b want 0 0", i, done, busy); else passed++;
         total++; if (ZlowOut !== el[i]) $display("FAIL mul%0d_hold: got %h want %h", i, ZlowOut, el[i]); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int cyc = -1;
      @(negedge clock);
      start = 1'b1; op = 1'b0; a_in = 32'd7; b_in = 32'hFFFFFFFD;
      @(posedge clock);
      #1;
      a_in = 32'd3; b_in = 32'd4;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done) begin cyc = i + 1; break; end
      end
      total++; if (cyc != 17) $display("FAIL b2b_latency: got %0d want 17", cyc); else passed++;
      total++; if (ZhighOut !== 32'hFFFFFFFF || ZlowOut !== 32'hFFFFFFEB)
         $display("FAIL b2b_result: got %h_%h want ffffffff_ffffffeb", ZhighOut, ZlowOut); else passed++;
      @(negedge clock);
      total++; if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL b2b_ignored_at_done_edge: got busy=%b done=%b want 0 0", busy, done); else passed++;
      start = 1'b0;
      @(negedge clock);
      total++; if (busy !== 1'b0 || ZlowOut !== 32'hFFFFFFEB)
         $display("FAIL b2b_hold: got busy=%b zlow=%h want 0 ffffffeb", busy, ZlowOut); else passed++;
   endtask

   task automatic test_abort();
      int cyc; logic [31:0] zh; logic [31:0] zl; logic dz; logic bs;
      int dones = 0;
      @(negedge clock);
      start = 1'b1; op = 1'b0; a_in = 32'h00012345; b_in = 32'h00006789;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (8) @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      total++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0)
         $display("FAIL abort_ctrl: got busy=%b done=%b dbz=%b want 0 0 0", busy, done, div_by_zero); else passed++;
      total++; if (ZhighOut !== 32'h0 || ZlowOut !== 32'h0)
         $display("FAIL abort_z: got %h_%h want 0_0", ZhighOut, ZlowOut); else passed++;
      clear = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (done || busy) dones++;
      end
      total++; if (dones != 0) $display("FAIL abort_no_done: got %0d active cycles want 0", dones); else passed++;
      run_op(1'b0, 32'd3, 32'd4, cyc, zh, zl, dz, bs);
      total++; if (cyc != 17) $display("FAIL abort_mul_latency: got %0d want 17", cyc); else passed++;
      total++; if (zh !== 32'h0 || zl !== 32'd12)
         $display("FAIL abort_mul_result: got %h_%h want 00000000_0000000c", zh, zl); else passed++;
   endtask

`ifdef MULDIV_DIV_EN
   task automatic test_div();
      logic [31:0] va [4] = '{32'hFFFFFFF9, 32'h80000000, 32'd9, 32'd100};
      logic [31:0] vb [4] = '{32'd2, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFF9};
      logic [31:0] eq [4] = '{32'hFFFFFFFD, 32'h80000000, 32'd3, 32'hFFFFFFF2};
      logic [31:0] er [4] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'd2};
      int cyc; logic [31:0] zh; logic [31:0] zl; logic dz; logic bs;
      for (int i = 0; i < 4; i++) begin
         run_op(1'b1, va[i], vb[i], cyc, zh, zl, dz, bs);
         total++; if (cyc != 34) $display("FAIL div%0d_latency: got %0d want 34", i, cyc); else passed++;
         total++; if (zl !== eq[i]) $display("FAIL div%0d_quo: got %h want %h", i, zl, eq[i]); else passed++;
         total++; if (zh !== er[i]) $display("FAIL div%0d_rem: got %h want %h", i, zh, er[i]); else passed++;
         total++; if (dz !== 1'b0) $display("FAIL div%0d_dbz: got %b want 0", i, dz); else passed++;
         @(negedge clock);
      end
   endtask

   task automatic test_div_by_zero();
      int cyc; logic [31:0] zh; logic [31:0] zl; logic dz; logic bs;
      run_op(1'b1, 32'd5, 32'd0, cyc, zh, zl, dz, bs);
      total++; if (cyc != 2) $display("FAIL dbz_latency: got %0d want 2", cyc); else passed++;
      total++; if (dz !== 1'b1) $display("FAIL dbz_flag: got %b want 1", dz); else passed++;
      total++; if (zl !== 32'hFFFFFFFF || zh !== 32'd5)
         $display("FAIL dbz_result: got %h_%h want 00000005_ffffffff", zh, zl); else passed++;
      @(negedge clock);
      total++; if (div_by_zero !== 1'b0 || done !== 1'b0)
         $display("FAIL dbz_after: got dbz=%b done=%b want 0 0", div_by_zero, done); else passed++;
      run_op(1'b1, 32'd9, 32'd3, cyc, zh, zl, dz, bs);
      total++; if (cyc != 34 || dz !== 1'b0)
         $display("FAIL dbz_next_flags: got cyc=%0d dbz=%b want 34 0", cyc, dz); else passed++;
      total++; if (zl !== 32'd3 || zh !== 32'd0)
         $display("FAIL dbz_next_result: got %h_%h want 00000000_00000003", zh, zl); else passed++;
      @(negedge clock);
   endtask
`else
   task automatic test_div_disabled();
      int active = 0;
      @(negedge clock);
      start = 1'b1; op = 1'b1; a_in = 32'd5; b_in = 32'd7;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (busy || done) active++;
      end
      total++; if (active != 0) $display("FAIL nodiv_busy: got %0d active cycles want 0", active); else passed++;
      total++; if (ZhighOut !== 32'h0 || ZlowOut !== 32'd12)
         $display("FAIL nodiv_hold: got %h_%h want 00000000_0000000c", ZhighOut, ZlowOut); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_mul();
      test_back_to_back();
      test_abort();
`ifdef MULDIV_DIV_EN
      test_div();
      test_div_by_zero();
`else
      test_div_disabled();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
